// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic array edge feeders: controller state
// encoding, flush-length arithmetic and lane slicing helpers.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_t;

  // Zero-injection cycles needed after the last beat so the deepest lane
  // drains and the PE accumulate pipeline absorbs the final product.
  function automatic int flush_len(input int lanes, input int flush_extra);
    return lanes - 1 + flush_extra;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// DEPTH-stage shift register with zero reset; the last stage is the
// registered output seen by the array.
module skew_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic array: accepts LANES-wide beats and emits them
// diagonally skewed, with a leading PE clear and a trailing zero flush.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LANES       = 4,
  parameter int FLUSH_EXTRA = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   pe_clear,
  output logic                   busy,
  output logic                   done
);

  localparam int FLUSH_LEN = flush_len(LANES, FLUSH_EXTRA);
  localparam int CNT_RAW   = $clog2(LANES + FLUSH_EXTRA);
  localparam int CNT_W     = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'((FLUSH_LEN < 1) ? 0 : FLUSH_LEN - 1);

  feeder_state_t    state;
  feeder_state_t    state_next;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] flush_cnt_next;
  logic             accept;
  logic [LANES*WIDTH-1:0] inject;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      flush_cnt <= '0;
      pe_clear  <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      pe_clear  <= (state == CLEAR);
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        state_next = STREAM;
      end
      STREAM: begin
        if (accept && in_last) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (flush_cnt == '0) begin
          state_next = DONE;
        end else begin
          flush_cnt_next = flush_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beats are held off while the clear pulse is on the array so the first
  // product cannot collide with the accumulator reset.
  assign in_ready = (state == STREAM) && !pe_clear;
  assign accept   = in_ready && in_valid;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign inject   = accept ? in_data : '0;

  for (genvar r = 0; r < LANES; r++) begin : g_lane
    localparam int LSB = lane_lsb(r, WIDTH);
    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(r + 1)
    ) u_delay (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (inject[LSB +: WIDTH]),
      .dout   (out_data[LSB +: WIDTH])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized self-checking bench for systolic_skew_feeder against a
// timestamp-and-history model of the feeder's visible behaviour.
module tb_systolic_skew_feeder;

  localparam int W         = 16;
  localparam int L         = 4;
  localparam int FE        = 2;
  localparam int FLUSH_LEN = L - 1 + FE;
  localparam int BIG       = 1 << 30;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic           in_valid;
  logic           in_ready;
  logic [L*W-1:0] in_data;
  logic           in_last;
  logic [L*W-1:0] out_data;
  logic           pe_clear;
  logic           busy;
  logic           done;

  int errors = 0;
  int checks = 0;

  systolic_skew_feeder #(
    .WIDTH      (W),
    .LANES      (L),
    .FLUSH_EXTRA(FE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_last (in_last),
    .out_data(out_data),
    .pe_clear(pe_clear),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: tile boundaries as edge timestamps, injected vectors as a history.
  int             cyc = 0;
  bit             act = 1'b0;
  int             e0 = 0;
  int             el = BIG;
  logic [L*W-1:0] hist [L];
  logic           expReady = 1'b0;
  logic           expBusy = 1'b0;
  logic           expClear = 1'b0;
  logic           expDone = 1'b0;
  logic [L*W-1:0] expOut = '0;

  initial begin
    for (int r = 0; r < L; r++) hist[r] = '0;
  end

  always @(posedge clk) begin : model
    logic [L*W-1:0] inj;
    cyc++;
    if (!reset_n) begin
      act = 1'b0;
      for (int r = 0; r < L; r++) hist[r] = '0;
    end else begin
      inj = '0;
      if (expReady && in_valid) begin
        inj = in_data;
        if (in_last) el = cyc;
      end
      if (!expBusy && start) begin
        act = 1'b1;
        e0  = cyc;
        el  = BIG;
      end
      for (int r = L - 1; r > 0; r--) hist[r] = hist[r-1];
      hist[0] = inj;
    end
    expBusy  = act && cyc >= e0 && cyc <= el + FLUSH_LEN;
    expClear = act && cyc == e0 + 1;
    expReady = act && cyc >= e0 + 2 && cyc < el;
    expDone  = act && cyc == el + FLUSH_LEN;
    for (int r = 0; r < L; r++) expOut[r*W +: W] = hist[r][r*W +: W];
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (!reset_n) begin
        checkOutput("rst_out", out_data, '0);
        checkOutput("rst_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("rst_clear", {63'd0, pe_clear}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
      end else begin
        checkOutput("out_data", out_data, expOut);
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, expReady});
        checkOutput("pe_clear", {63'd0, pe_clear}, {63'd0, expClear});
        checkOutput("busy", {63'd0, busy}, {63'd0, expBusy});
        checkOutput("done", {63'd0, done}, {63'd0, expDone});
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one tile; bubbleAt forces one idle cycle once that many beats are sent.
  task automatic applyStimulus(input int nBeats, input int validPct, input bit holdStart, input int bubbleAt);
    int  sent = 0;
    int  guard = 0;
    bit  bubbled = 1'b0;
    bit  rdy;
    start = 1'b1;
    nextCycle();
    if (!holdStart) start = 1'b0;
    while (sent < nBeats && guard < 200) begin
      guard++;
      rdy = in_ready;
      if (rdy && sent == bubbleAt && !bubbled) begin
        in_valid = 1'b0;
        bubbled  = 1'b1;
      end else begin
        in_valid = ($urandom_range(99) < validPct);
      end
      in_data = {$urandom, $urandom};
      in_last = in_valid ? (sent == nBeats - 1) : 1'($urandom_range(1));
      nextCycle();
      if (rdy && in_valid) sent++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (guard >= 200) checkOutput("beat_timeout", 64'(sent), 64'(nBeats));
    guard = 0;
    while (!done && guard < 30) begin
      guard++;
      nextCycle();
    end
    if (holdStart) start = 1'b0;
    checkOutput("done_seen", {63'd0, done}, 64'd1);
    repeat ($urandom_range(3, 1)) nextCycle();
  endtask

  initial begin
    logic [L*W-1:0] vec;
    logic [L*W-1:0] expv;
    int g;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) nextCycle();

    // Single beat with literal expectations for every output cycle.
    vec = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    g = 0;
    while (!in_ready && g < 10) begin
      nextCycle();
      g++;
    end
    checkOutput("ready_latency", 64'(g), 64'd2);
    in_valid = 1'b1;
    in_data  = vec;
    in_last  = 1'b1;
    nextCycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      expv = '0;
      if (k < L) expv[k*W +: W] = vec[k*W +: W];
      checkOutput($sformatf("single_out_%0d", k), out_data, expv);
      checkOutput($sformatf("single_done_%0d", k), {63'd0, done}, {63'd0, k == 5});
      if (k < 5) nextCycle();
    end
    repeat (2) nextCycle();

    // Back-to-back beats with one bubble between beats 2 and 3.
    applyStimulus(4, 100, 1'b0, 2);

    // start held across the whole tile: only one tile may run.
    applyStimulus(3, 100, 1'b1, -1);
    checkOutput("held_start_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of streaming while lane 3 holds data.
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    g = 0;
    while (!in_ready && g < 10) begin
      nextCycle();
      g++;
    end
    in_valid = 1'b1;
    in_data  = {16'h3C00, 16'h0003, 16'h0002, 16'h0001};
    in_last  = 1'b0;
    nextCycle();
    in_valid = 1'b0;
    repeat (3) nextCycle();
    checkOutput("lane3_before_reset", 64'(out_data[3*W +: W]), 64'h3C00);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_out_now", out_data, '0);
    checkOutput("reset_busy_now", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("ready_after_reset", {63'd0, in_ready}, 64'd0);
      nextCycle();
    end

    // Randomized tiles.
    for (int t = 0; t < 12; t++) begin
      applyStimulus($urandom_range(6, 1), $urandom_range(90, 40), 1'($urandom_range(1)), -1);
    end

    repeat (3) nextCycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge feeder that drives the west (or north) boundary of the processing-element systolic array. It accepts one vector of LANES operands per beat over a valid/ready stream and emits them diagonally skewed, so lane r lags lane 0 by r cycles. Empty slots are filled with zeros. It issues the one-cycle accumulator clear to the array before a tile and pads with zeros after the last beat until every PE has absorbed its final product. One instance feeds in_a and a second instance feeds in_b; both receive the same in_valid/start sequence.

## Interface
- WIDTH, 16, operand width (fp16 bit pattern, passed through unmodified)
- LANES, 4, array rows (or columns) fed; must be ≥ 1
- FLUSH_EXTRA, 2, PE accumulate pipeline depth (multiply register + add register)
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a tile; sampled only in IDLE
- in_valid  in  1  beat present on in_data
- in_ready  out  1  feeder accepts a beat this cycle
- in_data  in  LANES*WIDTH  lane r at bits [r*WIDTH +: WIDTH]
- in_last  in  1  qualifies the final beat of the tile
- out_data  out  LANES*WIDTH  skewed edge operands to the array, registered
- pe_clear  out  1  synchronous active-high clear to the array's PE reset, registered
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse; final product is in every PE accumulator

## Operation
- States: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE: in_ready=0; out_data=0. start=1 → CLEAR.
- CLEAR: exactly one cycle; pe_clear=1 on the following cycle; → STREAM.
- STREAM: in_ready=1.
  - in_valid=1: accept the beat. Accepted with in_last=1 → FLUSH.
  - in_valid=0: inject a zero vector as a bubble. The bubble is a valid zero contribution; both feeders see identical bubbles, so alignment holds.
- FLUSH: in_ready=0. Inject zeros for LANES-1+FLUSH_EXTRA cycles, counted by a down-counter of width $clog2(LANES+FLUSH_EXTRA). On reaching 0 → DONE.
- DONE: done=1 for one cycle; → IDLE.
- Skew rule: lane r of out_data in cycle t equals lane r of the vector injected in cycle t-1-r. An injected vector is either an accepted beat or zeros.
- The delay lines shift every cycle in every state, so a zero drain is implicit.
- No arithmetic is performed on data; zero means all-zero bits (+0.0).
- start outside IDLE is ignored. in_last while in_valid=0 is ignored.
- reset_n low, in any state and at any time: state=IDLE, all delay-line registers=0, out_data=0, pe_clear=0, in_ready=0, busy=0, done=0, flush counter=0.

## Timing
- start sampled high at edge E0 → CLEAR during cycle E0..E1. pe_clear=1 during E1..E2. in_ready=1 from E2.
- Beat accepted at edge Ea:
  - lane 0 appears on out_data after Ea (latency 1).
  - lane r appears after edge Ea+r (latency 1+r).
- Last beat accepted at edge El → FLUSH runs from El. done is high during cycle El+LANES-1+FLUSH_EXTRA. With LANES=4 and FLUSH_EXTRA=2, done is high in cycle El+5..El+6.
- Zero-length tiles are not supported; every tile has ≥ 1 beat.
- in_ready depends only on state (no combinational path from in_valid).

## Structure
- Shared package systolic_pkg holds:
  - the feeder state enum (IDLE, CLEAR, STREAM, FLUSH, DONE)
  - the FLUSH_LEN = LANES-1+FLUSH_EXTRA constant function
  - the lane slice macro/function used by the array and feeders
- Sub-module skew_delay_line #(WIDTH, DEPTH): a DEPTH-stage zero-reset shift register. Lane r instantiates one with DEPTH=r+1, which includes the output register. The controller FSM stays in the top module.

## Test plan
- Reset mid-STREAM: deassert reset_n with lane 3 holding 0x3C00 → out_data=0, busy=0 immediately. After release, in_ready=0 until a new start.
- Single beat {0x3C00,0x4000,0x4200,0x4400} with in_last → lane 0=0x3C00 at +1, lane 1=0x4000 at +2, lane 2=0x4200 at +3, lane 3=0x4400 at +4. done 5 cycles after accept. Each lane emits exactly one nonzero word.
- Four back-to-back beats with a bubble (in_valid=0) between beats 2 and 3 → lane 0 sequence is b0,b1,0,b2,b3. Each lane r shows the same sequence shifted by r. pe_clear pulses once, before the first beat.
- start held high through the whole tile plus DONE → exactly one tile executes. A second tile starts only from IDLE, and its pe_clear follows done.
- Two feeders (a, b) plus a 4×4 PE array: 4-beat tile of identity × 2.0 → every diagonal accumulator reads 0x4000 when done pulses; off-diagonal accumulators read 0x0000.
